// File: rtl/winograd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : winograd_pkg
//  Description : Shared constants, scheduler state encoding and the
//                dimension-validity helper for the F(4x4,3x3) Winograd
//                tile scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package winograd_pkg;

  localparam int WG_TILE = 6;  // input tile side
  localparam int WG_OUT  = 4;  // output tile side (= tile stride)
  localparam int WG_KER  = 3;  // kernel side

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_FIRE   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_FINISH = 3'd6
  } wg_sched_state_t;

  // A side is usable when it holds a whole number of overlapping tiles:
  // value = 4k+2, at least one tile, and no larger than the RAM allows.
  function automatic logic wg_dim_valid(input int unsigned dim,
                                        input int unsigned max_dim);
    return (dim >= WG_TILE) && (dim <= max_dim) &&
           ((dim % WG_OUT) == (WG_KER - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/winograd_tile_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : winograd_tile_addr_gen
//  Description : Tile (tr,tcl) and in-tile element (i,j) counters plus the
//                row-major RAM address arithmetic for the fetch (6x6 window,
//                stride img_cols) and write-back (4x4 block, stride out_cols)
//                phases.
//  Ports       : clk, rst          - clock, async active-high reset
//                load              - latch dimensions, zero all counters
//                img_rows/img_cols - input map size (sampled on load)
//                wr_phase          - 1: 4x4 write geometry, 0: 6x6 read
//                step              - advance to next element
//                elem_clr          - restart element walk of current tile
//                tile_adv          - advance to next tile, restart elements
//                elem              - linear element index within the tile
//                last_tile         - current tile is the final one
//                rd_addr / wr_addr - input / output RAM addresses
//  Revision    : 1.0 - initial release
// ============================================================================
module winograd_tile_addr_gen
  import winograd_pkg::*;
#(
  parameter int MAX_DIM    = 34,
  parameter int ADDR_WIDTH = $clog2(MAX_DIM*MAX_DIM),
  parameter int DIM_WIDTH  = $clog2(MAX_DIM+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DIM_WIDTH-1:0]  img_rows,
  input  logic [DIM_WIDTH-1:0]  img_cols,
  input  logic                  wr_phase,
  input  logic                  step,
  input  logic                  elem_clr,
  input  logic                  tile_adv,
  output logic [5:0]            elem,
  output logic                  last_tile,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  logic [DIM_WIDTH-1:0] tr_q, tr_d, tc_q, tc_d;
  logic [DIM_WIDTH-1:0] cols_q, cols_d;
  logic [DIM_WIDTH-1:0] ntr_q, ntr_d, ntc_q, ntc_d;  // tiles per column / row
  logic [2:0]           i_q, i_d, j_q, j_d;
  logic [5:0]           elem_q, elem_d;
  logic [2:0]           j_last;

  logic [ADDR_WIDTH-1:0] row_a, col_a, cols_a;

  assign j_last = wr_phase ? 3'(WG_OUT - 1) : 3'(WG_TILE - 1);

  always_comb begin
    tr_d   = tr_q;
    tc_d   = tc_q;
    cols_d = cols_q;
    ntr_d  = ntr_q;
    ntc_d  = ntc_q;
    i_d    = i_q;
    j_d    = j_q;
    elem_d = elem_q;
    if (load) begin
      tr_d   = '0;
      tc_d   = '0;
      i_d    = '0;
      j_d    = '0;
      elem_d = '0;
      cols_d = img_cols;
      ntr_d  = (img_rows - DIM_WIDTH'(2)) >> 2;
      ntc_d  = (img_cols - DIM_WIDTH'(2)) >> 2;
    end else if (tile_adv) begin
      i_d    = '0;
      j_d    = '0;
      elem_d = '0;
      if (tc_q == ntc_q - DIM_WIDTH'(1)) begin
        tc_d = '0;
        tr_d = tr_q + DIM_WIDTH'(1);
      end else begin
        tc_d = tc_q + DIM_WIDTH'(1);
      end
    end else if (elem_clr) begin
      i_d    = '0;
      j_d    = '0;
      elem_d = '0;
    end else if (step) begin
      elem_d = elem_q + 6'd1;
      if (j_q == j_last) begin
        j_d = '0;
        i_d = i_q + 3'd1;
      end else begin
        j_d = j_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_q   <= '0;
      tc_q   <= '0;
      cols_q <= '0;
      ntr_q  <= '0;
      ntc_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      elem_q <= '0;
    end else begin
      tr_q   <= tr_d;
      tc_q   <= tc_d;
      cols_q <= cols_d;
      ntr_q  <= ntr_d;
      ntc_q  <= ntc_d;
      i_q    <= i_d;
      j_q    <= j_d;
      elem_q <= elem_d;
    end
  end

  // Both phases share the tile origin (4tr, 4tcl); only the row stride differs.
  assign row_a  = ADDR_WIDTH'({tr_q, 2'b00}) + ADDR_WIDTH'(i_q);
  assign col_a  = ADDR_WIDTH'({tc_q, 2'b00}) + ADDR_WIDTH'(j_q);
  assign cols_a = ADDR_WIDTH'(cols_q);

  assign rd_addr   = row_a * cols_a + col_a;
  assign wr_addr   = row_a * (cols_a - ADDR_WIDTH'(2)) + col_a;
  assign elem      = elem_q;
  assign last_tile = (tr_q == ntr_q - DIM_WIDTH'(1)) &&
                     (tc_q == ntc_q - DIM_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/winograd_tile_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : winograd_tile_scheduler
//  Description : Walks overlapping 6x6 input tiles (stride 4) across a
//                feature map, fetches each into a tile buffer, fires the
//                tile_controller, captures its 4x4 result and writes it to
//                the output map.
//  Ports       : clk, rst            - clock, async active-high reset
//                start               - request (honoured only when idle)
//                img_rows, img_cols  - input map size, sampled at start
//                rd_en/rd_addr/rd_data - input RAM (1-cycle read latency)
//                wr_en/wr_addr/wr_data - output RAM
//                tc_start/tc_tile    - tile_controller launch and operand
//                tc_result/tc_done   - tile_controller result and ready level
//                busy, done, error   - status
//  Revision    : 1.0 - initial release
// ============================================================================
module winograd_tile_scheduler
  import winograd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIM    = 34,
  parameter int ADDR_WIDTH = $clog2(MAX_DIM*MAX_DIM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(MAX_DIM+1)-1:0]        img_rows,
  input  logic [$clog2(MAX_DIM+1)-1:0]        img_cols,
  output logic                                rd_en,
  output logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                wr_en,
  output logic [ADDR_WIDTH-1:0]               wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                tc_start,
  output logic [0:5][0:5][DATA_WIDTH-1:0]     tc_tile,
  input  logic [0:3][0:3][DATA_WIDTH-1:0]     tc_result,
  input  logic                                tc_done,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);

  localparam int DIM_WIDTH = $clog2(MAX_DIM+1);

  wg_sched_state_t state_q, state_d;

  // Flat row-major tile buffer; same bit layout as the 6x6 port.
  logic [0:35][DATA_WIDTH-1:0]        tile_q, tile_d;
  logic [0:3][0:3][DATA_WIDTH-1:0]    result_q, result_d;
  logic                               cap_en_q, cap_en_d;
  logic [5:0]                         cap_idx_q, cap_idx_d;
  logic                               wait_first_q, wait_first_d;
  logic                               error_q, error_d;

  logic                  dims_ok;
  logic                  gen_load, gen_step, gen_elem_clr, gen_tile_adv, gen_wr_phase;
  logic [5:0]            elem;
  logic                  last_tile;
  logic [ADDR_WIDTH-1:0] gen_rd_addr, gen_wr_addr;

  assign dims_ok = wg_dim_valid(32'(img_rows), 32'(MAX_DIM)) &&
                   wg_dim_valid(32'(img_cols), 32'(MAX_DIM));

  winograd_tile_addr_gen #(
    .MAX_DIM    (MAX_DIM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (gen_load),
    .img_rows  (img_rows),
    .img_cols  (img_cols),
    .wr_phase  (gen_wr_phase),
    .step      (gen_step),
    .elem_clr  (gen_elem_clr),
    .tile_adv  (gen_tile_adv),
    .elem      (elem),
    .last_tile (last_tile),
    .rd_addr   (gen_rd_addr),
    .wr_addr   (gen_wr_addr)
  );

  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    result_d     = result_q;
    cap_en_d     = 1'b0;
    cap_idx_d    = elem;
    wait_first_d = wait_first_q;
    error_d      = 1'b0;
    gen_load     = 1'b0;
    gen_step     = 1'b0;
    gen_elem_clr = 1'b0;
    gen_tile_adv = 1'b0;
    gen_wr_phase = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    tc_start     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    // Read data lags its strobe by one cycle, so capture uses the delayed index.
    if (cap_en_q) begin
      tile_d[cap_idx_q] = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (dims_ok) begin
            gen_load = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        // 36 read cycles, then one more to land the last word.
        if (elem < 6'd36) begin
          rd_en    = 1'b1;
          cap_en_d = 1'b1;
          gen_step = 1'b1;
        end else begin
          gen_elem_clr = 1'b1;
          state_d      = ST_FIRE;
        end
      end
      ST_FIRE: begin
        tc_start     = 1'b1;
        wait_first_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // tc_done may still reflect the previous tile in the first cycle.
        wait_first_d = 1'b0;
        if (!wait_first_q && tc_done) begin
          result_d = tc_result;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        gen_wr_phase = 1'b1;
        wr_en        = 1'b1;
        gen_step     = 1'b1;
        if (elem == 6'd15) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        gen_tile_adv = 1'b1;
        state_d      = last_tile ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tile_q       <= '0;
      result_q     <= '0;
      cap_en_q     <= 1'b0;
      cap_idx_q    <= '0;
      wait_first_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_q       <= tile_d;
      result_q     <= result_d;
      cap_en_q     <= cap_en_d;
      cap_idx_q    <= cap_idx_d;
      wait_first_q <= wait_first_d;
      error_q      <= error_d;
    end
  end

  assign rd_addr = rd_en ? gen_rd_addr : '0;
  assign wr_addr = wr_en ? gen_wr_addr : '0;
  assign wr_data = wr_en ? result_q[elem[3:2]][elem[1:0]] : '0;
  assign tc_tile = tile_q;
  assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_winograd_tile_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_winograd_tile_scheduler
//  Description : Self-checking bench for winograd_tile_scheduler. Holds an
//                input RAM, an output scoreboard built from a direct 3x3
//                correlation of the whole map, a behavioural tile_controller
//                stand-in, and a per-cycle strobe timing model derived from
//                the per-tile cycle budget.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_winograd_tile_scheduler;

  localparam int DW   = 16;
  localparam int MD   = 34;
  localparam int AW   = $clog2(MD*MD);
  localparam int DIMW = $clog2(MD+1);

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic [DIMW-1:0]             img_rows = '0;
  logic [DIMW-1:0]             img_cols = '0;
  logic                        rd_en;
  logic [AW-1:0]               rd_addr;
  logic [DW-1:0]               rd_data = '0;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [DW-1:0]               wr_data;
  logic                        tc_start;
  logic [0:5][0:5][DW-1:0]     tc_tile;
  logic [0:3][0:3][DW-1:0]     tc_result = '0;
  logic                        tc_done = 1'b1;
  logic                        busy, done, error;

  winograd_tile_scheduler #(.DATA_WIDTH(DW), .MAX_DIM(MD), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_rows  (img_rows),
    .img_cols  (img_cols),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .tc_start  (tc_start),
    .tc_tile   (tc_tile),
    .tc_result (tc_result),
    .tc_done   (tc_done),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [DW-1:0] mem [0:MD*MD-1];
  int kern [3][3];
  int vec = 0, mis = 0;
  int cyc = 0;
  int tc_lat = 1, tc_cnt = 0;
  int run_kind = 0;  // 0 idle, 1 valid run, 2 rejected start
  int run_s = 0, run_tiles = 0, run_cost = 0, run_tw = 0, run_lat = 0;
  int exp_rd_q[$];
  int exp_wa_q[$];
  int exp_wd_q[$];
  int rd_log_a[$];
  int wr_log_a[$];
  int wr_log_d[$];
  int rd_cnt = 0, wr_cnt = 0, tcs_cnt = 0, err_cnt = 0, max_wa = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Input RAM: data one cycle after the strobe.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // tile_controller stand-in: done drops on start, rises tc_lat cycles later
  // with the 3x3 correlation of the tile currently presented.
  always @(posedge clk) begin
    if (rst) begin
      tc_done <= 1'b1;
    end else if (tc_start) begin
      tc_done <= 1'b0;
      tc_cnt  <= tc_lat;
    end else if (!tc_done) begin
      if (tc_cnt <= 1) begin
        tc_done <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            int s;
            s = 0;
            for (int a = 0; a < 3; a++)
              for (int b = 0; b < 3; b++)
                s += kern[a][b] * int'(tc_tile[i+a][j+b]);
            tc_result[i][j] <= s[DW-1:0];
          end
        end
      end else begin
        tc_cnt <= tc_cnt - 1;
      end
    end
  end

  function automatic int ref_out(input int r, input int c, input int cols);
    int s;
    s = 0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        s += kern[a][b] * int'(mem[(r+a)*cols + c + b]);
    return int'(s[DW-1:0]);
  endfunction

  function automatic bit dim_ok(input int d);
    return (d >= 6) && (d <= MD) && ((d % 4) == 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic eb, ed, ee, et, er, ew;
    int off, e_a, e_d;
    if (!rst && chk_en) begin
      eb = 0; ed = 0; ee = 0; et = 0; er = 0; ew = 0;
      if (run_kind == 1) begin
        eb = (cyc > run_s) && (cyc < run_s + run_lat);
        ed = (cyc == run_s + run_lat);
        if (eb) begin
          off = (cyc - run_s - 1) % run_cost;
          er  = off < 36;
          et  = off == 37;
          ew  = (off >= 38 + run_tw) && (off < 54 + run_tw);
        end
      end else if (run_kind == 2) begin
        ee = (cyc == run_s + 1);
      end
      vec++;
      if ({busy, done, error, tc_start, rd_en, wr_en} !== {eb, ed, ee, et, er, ew}) begin
        mis++;
        $display("FAIL strobes cyc=%0d: busy/done/err/tcs/rd/wr got %b%b%b%b%b%b expected %b%b%b%b%b%b",
                 cyc - run_s, busy, done, error, tc_start, rd_en, wr_en, eb, ed, ee, et, er, ew);
      end
      if (rd_en) begin
        rd_cnt++;
        rd_log_a.push_back(int'(rd_addr));
        vec++;
        if (exp_rd_q.size() == 0) begin
          mis++;
          $display("FAIL rd_extra: got addr %0d expected no read", rd_addr);
        end else begin
          e_a = exp_rd_q.pop_front();
          if (int'(rd_addr) != e_a) begin
            mis++;
            $display("FAIL rd_addr: got %0d expected %0d", rd_addr, e_a);
          end
        end
      end
      if (wr_en) begin
        wr_cnt++;
        wr_log_a.push_back(int'(wr_addr));
        wr_log_d.push_back(int'(wr_data));
        if (int'(wr_addr) > max_wa) max_wa = int'(wr_addr);
        vec++;
        if (exp_wa_q.size() == 0) begin
          mis++;
          $display("FAIL wr_extra: got addr %0d data %0d expected no write", wr_addr, wr_data);
        end else begin
          e_a = exp_wa_q.pop_front();
          e_d = exp_wd_q.pop_front();
          if (int'(wr_addr) != e_a || int'(wr_data) != e_d) begin
            mis++;
            $display("FAIL wr: got addr %0d data %0d expected addr %0d data %0d",
                     wr_addr, wr_data, e_a, e_d);
          end
        end
      end
      if (tc_start) tcs_cnt++;
      if (error) err_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill(input int rows, input int cols, input int mode);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        case (mode)
          0:       mem[r*cols + c] = DW'(r*cols + c + 1);
          1:       mem[r*cols + c] = DW'(1);
          default: mem[r*cols + c] = DW'($urandom_range(0, 1023));
        endcase
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        case (mode)
          0:       kern[a][b] = (a == 1 && b == 1) ? 1 : 0;
          1:       kern[a][b] = 1;
          default: kern[a][b] = int'($urandom_range(0, 7));
        endcase
  endtask

  task automatic plan(input int rows, input int cols);
    int oc;
    oc = cols - 2;
    run_tiles = ((rows - 2) / 4) * (oc / 4);
    for (int tr = 0; tr < (rows - 2) / 4; tr++)
      for (int tc = 0; tc < oc / 4; tc++) begin
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++)
            exp_rd_q.push_back((4*tr + i)*cols + 4*tc + j);
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            exp_wa_q.push_back((4*tr + i)*oc + 4*tc + j);
            exp_wd_q.push_back(ref_out(4*tr + i, 4*tc + j, cols));
          end
      end
  endtask

  task automatic launch(input int rows, input int cols, input int lat);
    @(posedge clk); #1;
    tc_lat   = lat;
    run_tw   = lat + 1;
    run_cost = 37 + 1 + run_tw + 16 + 1;
    rd_cnt = 0; wr_cnt = 0; tcs_cnt = 0; err_cnt = 0; max_wa = 0;
    rd_log_a.delete(); wr_log_a.delete(); wr_log_d.delete();
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    run_s = cyc;
    if (dim_ok(rows) && dim_ok(cols)) begin
      plan(rows, cols);
      run_lat  = run_tiles * run_cost + 1;
      run_kind = 1;
    end else begin
      run_lat  = 1;
      run_kind = 2;
    end
    img_rows = DIMW'(rows);
    img_cols = DIMW'(cols);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    img_rows = DIMW'($urandom);
    img_cols = DIMW'($urandom);
  endtask

  task automatic finish_run();
    repeat (run_lat + 3) @(posedge clk);
    #1;
    run_kind = 0;
    chk("rd_left", exp_rd_q.size(), 0);
    chk("wr_left", exp_wa_q.size(), 0);
  endtask

  task automatic go(input int rows, input int cols, input int lat);
    launch(rows, cols, lat);
    finish_run();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nines, k, r, c;
    int bad_dims[4];
    bad_dims[0] = 7; bad_dims[1] = 2; bad_dims[2] = 38; bad_dims[3] = 8;

    #1;
    chk("reset_strobes", int'({rd_en, wr_en, tc_start, busy, done, error}), 0);
    chk("reset_addrs", int'(rd_addr) + int'(wr_addr) + int'(wr_data), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Single 6x6 tile, center-tap kernel: output is the inner 4x4 of input.
    fill(6, 6, 0);
    go(6, 6, 1);
    chk("t1_writes", wr_cnt, 16);
    chk("t1_data0", wr_log_d[0], 8);
    chk("t1_data4", wr_log_d[4], 14);
    chk("t1_data15", wr_log_d[15], 29);
    chk("t1_addr15", wr_log_a[15], 15);

    // 10x10 all ones: four tiles, every output 9.
    fill(10, 10, 1);
    go(10, 10, 2);
    chk("t2_writes", wr_cnt, 64);
    nines = 0;
    foreach (wr_log_d[i]) if (wr_log_d[i] == 9) nines++;
    chk("t2_all_nine", nines, 64);
    chk("t2_rd6", rd_log_a[6], 10);
    chk("t2_rd35", rd_log_a[35], 55);
    chk("t2_tiles", tcs_cnt, 4);

    // 6x10: two tiles side by side, out_cols = 8.
    fill(6, 10, 2);
    go(6, 10, 1);
    chk("t3_writes", wr_cnt, 32);
    chk("t3_max_waddr", max_wa, 31);

    // Rejected dimensions.
    foreach (bad_dims[i]) begin
      go(bad_dims[i], 10, 1);
      chk("bad_err", err_cnt, 1);
      chk("bad_rw", rd_cnt + wr_cnt, 0);
    end
    go(10, 12, 1);
    chk("bad_cols_err", err_cnt, 1);

    // start re-pulsed while waiting on the tile engine.
    fill(10, 10, 2);
    launch(10, 10, 3);
    for (k = 0; k < 5000 && tcs_cnt < 1; k++) @(posedge clk);
    #1;
    chk("t5_reached_wait", int'(tcs_cnt >= 1), 1);
    img_rows = DIMW'(6); img_cols = DIMW'(6); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run();
    chk("t5_writes", wr_cnt, 64);

    // Randomized valid maps.
    for (int n = 0; n < 4; n++) begin
      r = 4 * int'($urandom_range(1, (n == 0) ? 8 : 4)) + 2;
      c = 4 * int'($urandom_range(1, 8)) + 2;
      fill(r, c, 2);
      go(r, c, int'($urandom_range(1, 5)));
      chk("rnd_writes", wr_cnt, (r - 2) * (c - 2));
    end

    // Reset in the middle of fetching the third tile, then a clean rerun.
    fill(18, 18, 2);
    launch(18, 18, 2);
    for (k = 0; k < 5000 && rd_cnt < 2*36 + 5; k++) @(posedge clk);
    chk("t6_reached_tile2", int'(rd_cnt >= 2*36 + 5), 1);
    #3 rst = 1'b1;
    run_kind = 0;
    #1;
    chk("t6_rst_strobes", int'({rd_en, wr_en, tc_start, busy, done, error}), 0);
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fill(10, 10, 2);
    go(10, 10, 2);
    chk("t6_rerun_writes", wr_cnt, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/winograd_tile_scheduler.md
# winograd_tile_scheduler

Sequences one `tile_controller` instance across a full input feature map for F(4x4,3x3) Winograd convolution: walks overlapping 6x6 input tiles (stride 4), fetches each from input memory, fires the tile engine, and writes each 4x4 result into output memory. Sits between the feature-map RAMs and `tile_controller`. The 3x3 kernel is driven to `tile_controller` directly by upstream logic and is not handled here.

## Interface
Parameters:
- `DATA_WIDTH`, 16, element width.
- `MAX_DIM`, 34, maximum image side, in elements.
- `ADDR_WIDTH`, `$clog2(MAX_DIM*MAX_DIM)`, RAM address width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `img_rows`, `img_cols`  in  `$clog2(MAX_DIM+1)` each  input dimensions; sampled at `start`.
- `rd_en`  out  1  input-RAM read strobe.
- `rd_addr`  out  ADDR_WIDTH  input-RAM address.
- `rd_data`  in  DATA_WIDTH  input-RAM data; valid exactly 1 cycle after `rd_en`.
- `wr_en`  out  1  output-RAM write strobe.
- `wr_addr`  out  ADDR_WIDTH  output-RAM address.
- `wr_data`  out  DATA_WIDTH  output-RAM data.
- `tc_start`  out  1  one-cycle start pulse to `tile_controller`.
- `tc_tile`  out  `[0:5][0:5]` x DATA_WIDTH  tile to `tile_controller`; held stable from `tc_start` until the result is captured.
- `tc_result`  in  `[0:3][0:3]` x DATA_WIDTH  result from `tile_controller`.
- `tc_done`  in  1  level from `tile_controller`: low while computing, high when the result is valid.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the whole map has been written.
- `error`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- Dimensions are valid only if `img_rows` and `img_cols` are each 4k+2 with 6 ≤ value ≤ MAX_DIM.
- On invalid dimensions, `error` pulses in the cycle after `start`, and no reads, writes or `tc_start` are issued.
- Output map is `out_rows = img_rows-2` by `out_cols = img_cols-2`.
- Tiles are visited row-major: tile (tr,tcl) for tr in 0..out_rows/4-1 and tcl in 0..out_cols/4-1.
- The input origin of tile (tr,tcl) is (4·tr, 4·tcl).
- States: IDLE → FETCH → FIRE → WAIT → WRITE → NEXT → (FETCH or FINISH) → IDLE.
- FETCH:
  - Issues 36 reads row-major within the tile: `rd_addr = (4tr+i)·img_cols + 4tcl+j`.
  - `rd_data` is captured into the tile buffer one cycle later.
  - The state takes 37 cycles.
- FIRE: `tc_start` is high for 1 cycle.
- WAIT:
  - `tc_done` is ignored in the first WAIT cycle.
  - After that, the first cycle with `tc_done`=1 latches `tc_result` into the result buffer.
- WRITE:
  - 16 consecutive `wr_en` cycles, row-major.
  - `wr_addr = (4tr+i)·out_cols + 4tcl+j`.
  - `wr_data` comes from the result buffer.
- NEXT: advances tcl, wraps it to 0 and increments tr. After the last tile, the next state is FINISH.
- FINISH: `done` pulses and `busy` falls in the same cycle; return to IDLE.
- Address arithmetic is unsigned at ADDR_WIDTH. Products never overflow under valid dimensions.
- `start` while busy is ignored. No queueing.

## Timing
- Reset values:
  - state IDLE.
  - `rd_en`, `wr_en`, `tc_start`, `busy`, `done`, `error` = 0.
  - `rd_addr`, `wr_addr`, `wr_data` = 0.
  - Tile and result buffers = 0.
- Reset asserted mid-operation aborts immediately. No further reads or writes. A partially written output map is left as is.
- `busy` rises the cycle after an accepted `start`.
- Per-tile cost: 37 (FETCH) + 1 (FIRE) + T_wait + 16 (WRITE) + 1 (NEXT), where T_wait ≥ 2 is set by `tile_controller`.
- Total latency: tiles × per-tile cost + 1 (FINISH).
- `wr_*` and `rd_*` are never active in the same cycle.

## Structure
- Shared package `winograd_pkg`:
  - Constants `WG_TILE=6`, `WG_OUT=4`, `WG_KER=3`.
  - State enum `wg_sched_state_t`.
  - Helper function `wg_dim_valid()`.
- Sub-module `winograd_tile_addr_gen`: tile/element counters and the row-major address computation for both read and write phases.
- The top level holds the FSM, tile buffer and result buffer.

## Test plan
- 6x6 input with value i·6+j+1, center-1 kernel, real `tile_controller` → exactly one tile; 16 writes to addresses 0..15 with data 8,9,10,11,14,…,29; then `done`.
- 10x10 input, all-ones kernel and data → 4 tiles in order (0,0),(0,1),(1,0),(1,1); 64 writes each of value 9; first-tile read addresses 0..5, 10..15, …; `done` after the last write.
- 6x10 input → 2 tiles; `wr_addr` values are within 0..31 with `out_cols`=8.
- `img_rows`=7 → `error` pulse one cycle after `start`; `busy` stays 0; zero reads and zero writes.
- `start` re-pulsed during WAIT → ignored; the write count is unchanged.
- `rst` asserted during FETCH of tile 2 → all strobes 0 in the same cycle; after release, a new `start` runs to `done` correctly.
